// File: rtl/coord_parser.sv
// coord_parser
//   Splits a packed {x, y, z} word into three coordinate fields and presents
//   them through a registered output stage. A FIFO_DEPTH-entry FIFO sits
//   behind that stage, so the whole block queues up to FIFO_DEPTH+1 words.
//   There is no input backpressure. A word that arrives while the queue is
//   full, and is not freed by an accept on the same edge, is dropped.
//
// Ports
//   clk           : single clock, rising edge
//   reset_n       : asynchronous active-low reset
//   data_in       : packed word {x, y, z}, x in the MSBs
//   data_in_valid : data_in is offered this cycle
//   x/y/z_coord   : fields of the presented word (registered)
//   data_valid    : presented word is unconsumed
//   data_ready    : consumer accepts when data_valid && data_ready
module coord_parser #(
  parameter int COORD_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3*COORD_W-1:0] data_in,
  input  logic                 data_in_valid,
  output logic [COORD_W-1:0]   x_coord,
  output logic [COORD_W-1:0]   y_coord,
  output logic [COORD_W-1:0]   z_coord,
  output logic                 data_valid,
  input  logic                 data_ready
);

  localparam int WORD_W = 3 * COORD_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;

  logic [WORD_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic              mem_we;

  logic accept;
  logic out_free;
  logic fifo_empty;
  logic fifo_full;

  always_comb begin
    out_d    = out_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;

    accept     = valid_q & data_ready;
    out_free   = ~valid_q | accept;
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));

    if (out_free) begin
      if (!fifo_empty) begin
        // Head moves to the output. An incoming word takes the freed slot,
        // so the occupancy is unchanged in that case. When the FIFO was full
        // the write lands on the slot being read, which is safe because the
        // read uses the pre-edge contents.
        out_d    = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (data_in_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (data_in_valid) begin
        // Bypass: an empty queue loads straight into the output register.
        out_d   = data_in;
        valid_d = 1'b1;
      end else begin
        // The output value is kept after an accept; only the valid flag drops.
        valid_d = 1'b0;
      end
    end else if (data_in_valid && !fifo_full) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset because the pointers and the count define which
  // entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign x_coord    = out_q[WORD_W-1 -: COORD_W];
  assign y_coord    = out_q[2*COORD_W-1 -: COORD_W];
  assign z_coord    = out_q[COORD_W-1:0];
  assign data_valid = valid_q;

endmodule

// File: tb/tb_coord_parser.sv
module tb_coord_parser;

  logic        clk;
  logic        reset_n;
  logic [47:0] data_in;
  logic        data_in_valid;
  logic [15:0] x_coord, y_coord, z_coord;
  logic        data_valid;
  logic        data_ready;

  int errors = 0;
  int checks = 0;

  coord_parser #(.COORD_W(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .x_coord      (x_coord),
    .y_coord      (y_coord),
    .z_coord      (z_coord),
    .data_valid   (data_valid),
    .data_ready   (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    data_in = '0;
    data_in_valid = 1'b0;
    data_ready = 1'b0;
    #3;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (x_coord !== 16'h0000) begin errors++; $display("FAIL reset_x got=%h exp=0000", x_coord); end
    checks++; if (y_coord !== 16'h0000) begin errors++; $display("FAIL reset_y got=%h exp=0000", y_coord); end
    checks++; if (z_coord !== 16'h0000) begin errors++; $display("FAIL reset_z got=%h exp=0000", z_coord); end
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    data_in = {16'd10, 16'd20, 16'd30};
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", data_valid); end
    checks++; if (x_coord !== 16'h000a) begin errors++; $display("FAIL single_x got=%h exp=000a", x_coord); end
    checks++; if (y_coord !== 16'h0014) begin errors++; $display("FAIL single_y got=%h exp=0014", y_coord); end
    checks++; if (z_coord !== 16'h001e) begin errors++; $display("FAIL single_z got=%h exp=001e", z_coord); end
    cycle();
    cycle();
    checks++; if (data_valid !== 1'b1 || x_coord !== 16'h000a) begin errors++; $display("FAIL single_hold got=%b/%h exp=1/000a", data_valid, x_coord); end
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got=%b exp=0", data_valid); end
    checks++; if (x_coord !== 16'h000a || z_coord !== 16'h001e) begin errors++; $display("FAIL single_retain got=%h/%h exp=000a/001e", x_coord, z_coord); end
    // data_ready while nothing is valid must not disturb anything
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", data_valid); end
  endtask

  task automatic test_sequence();
    data_in = {16'd15, 16'd25, 16'd35};
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    checks++; if ({x_coord, y_coord, z_coord} !== {16'h000f, 16'h0019, 16'h0023}) begin errors++; $display("FAIL seq_a got=%h/%h/%h exp=000f/0019/0023", x_coord, y_coord, z_coord); end
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL seq_a_consumed got=%b exp=0", data_valid); end
    data_in = {16'd1023, 16'd511, 16'd255};
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    checks++; if (data_valid !== 1'b1 || {x_coord, y_coord, z_coord} !== {16'h03ff, 16'h01ff, 16'h00ff}) begin errors++; $display("FAIL seq_b got=%b %h/%h/%h exp=1 03ff/01ff/00ff", data_valid, x_coord, y_coord, z_coord); end
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL seq_b_consumed got=%b exp=0", data_valid); end
  endtask

  task automatic test_burst();
    logic [15:0] exp_x [5];
    logic [15:0] exp_z [5];
    exp_x = '{16'h0001, 16'h0004, 16'h0007, 16'h000a, 16'h000d};
    exp_z = '{16'h0003, 16'h0006, 16'h0009, 16'h000c, 16'h000f};
    data_in_valid = 1'b1;
    data_in = {16'd1,  16'd2,  16'd3};  cycle();
    data_in = {16'd4,  16'd5,  16'd6};  cycle();
    data_in = {16'd7,  16'd8,  16'd9};  cycle();
    data_in = {16'd10, 16'd11, 16'd12}; cycle();
    data_in = {16'd13, 16'd14, 16'd15}; cycle();
    data_in = {16'd99, 16'd99, 16'd99}; cycle();
    data_in_valid = 1'b0;
    cycle();
    checks++; if (data_valid !== 1'b1 || x_coord !== 16'h0001) begin errors++; $display("FAIL burst_head got=%b/%h exp=1/0001", data_valid, x_coord); end
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_valid !== 1'b1 || x_coord !== exp_x[i] || z_coord !== exp_z[i]) begin
        errors++;
        $display("FAIL burst_drain[%0d] got=%b %h/%h exp=1 %h/%h", i, data_valid, x_coord, z_coord, exp_x[i], exp_z[i]);
      end
      cycle();
    end
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL burst_dropped got=%b x=%h exp=0", data_valid, x_coord); end
  endtask

  task automatic test_full_accept();
    logic [15:0] exp_x [5];
    exp_x = '{16'h0021, 16'h0031, 16'h0041, 16'h0051, 16'h0061};
    data_in_valid = 1'b1;
    data_in = {16'h0011, 16'd0, 16'd0}; cycle();
    data_in = {16'h0021, 16'd0, 16'd0}; cycle();
    data_in = {16'h0031, 16'd0, 16'd0}; cycle();
    data_in = {16'h0041, 16'd0, 16'd0}; cycle();
    data_in = {16'h0051, 16'd0, 16'd0}; cycle();
    // Full, but the accept on this edge frees space: word must be kept.
    data_in = {16'h0061, 16'd0, 16'd0};
    data_ready = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_valid !== 1'b1 || x_coord !== exp_x[i]) begin
        errors++;
        $display("FAIL full_accept[%0d] got=%b/%h exp=1/%h", i, data_valid, x_coord, exp_x[i]);
      end
      cycle();
    end
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL full_accept_end got=%b exp=0", data_valid); end
  endtask

  task automatic test_back_to_back();
    data_in = {16'h00aa, 16'h00bb, 16'h00cc};
    data_in_valid = 1'b1;
    cycle();
    checks++; if (x_coord !== 16'h00aa) begin errors++; $display("FAIL b2b_first got=%h exp=00aa", x_coord); end
    data_in = {16'h0123, 16'h0456, 16'h0789};
    data_ready = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", data_valid); end
    checks++; if ({x_coord, y_coord, z_coord} !== {16'h0123, 16'h0456, 16'h0789}) begin errors++; $display("FAIL b2b_switch got=%h/%h/%h exp=0123/0456/0789", x_coord, y_coord, z_coord); end
    cycle();
    checks++; if (x_coord !== 16'h0123 || data_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%b/%h exp=1/0123", data_valid, x_coord); end
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", data_valid); end
  endtask

  task automatic test_reset_mid();
    data_in_valid = 1'b1;
    data_in = {16'd1, 16'd1, 16'd1}; cycle();
    data_in = {16'd2, 16'd2, 16'd2}; cycle();
    data_in = {16'd3, 16'd3, 16'd3}; cycle();
    data_in_valid = 1'b0;
    checks++; if (data_valid !== 1'b1 || x_coord !== 16'h0001) begin errors++; $display("FAIL rmid_pre got=%b/%h exp=1/0001", data_valid, x_coord); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", data_valid); end
    checks++; if ({x_coord, y_coord, z_coord} !== 48'h0) begin errors++; $display("FAIL rmid_zero got=%h/%h/%h exp=0000/0000/0000", x_coord, y_coord, z_coord); end
    // Input offered while in reset is ignored.
    data_in = {16'd7, 16'd7, 16'd7};
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_ignored got=%b exp=0", data_valid); end
    #2;
    reset_n = 1'b1;
    cycle();
    data_in = {16'h0055, 16'h0066, 16'h0077};
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    checks++; if (data_valid !== 1'b1 || {x_coord, y_coord, z_coord} !== {16'h0055, 16'h0066, 16'h0077}) begin errors++; $display("FAIL rmid_new got=%b %h/%h/%h exp=1 0055/0066/0077", data_valid, x_coord, y_coord, z_coord); end
    data_ready = 1'b1;
    cycle();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_alone got=%b x=%h exp=0", data_valid, x_coord); end
    cycle();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_empty got=%b x=%h exp=0", data_valid, x_coord); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_burst();
    test_full_accept();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coord_parser.md
COORD_PARSER -- requirements
Module: coord_parser

Interface
REQ-001 The block SHALL have parameter COORD_W, default 16, giving the width of each coordinate field.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2), giving the number of buffered input words behind the output register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, 3*COORD_W bits: packed word {x, y, z}, with x in the MSBs.
REQ-006 The block SHALL have port data_in_valid, input, 1 bit: data_in is offered this cycle; there is no input backpressure.
REQ-007 The block SHALL have port x_coord, output, COORD_W bits: x field of the presented word.
REQ-008 The block SHALL have port y_coord, output, COORD_W bits: y field of the presented word.
REQ-009 The block SHALL have port z_coord, output, COORD_W bits: z field of the presented word.
REQ-010 The block SHALL have port data_valid, output, 1 bit: the coordinate outputs hold an unconsumed word.
REQ-011 The block SHALL have port data_ready, input, 1 bit: the consumer accepts the word on an edge where data_valid=1 and data_ready=1.

Function
REQ-012 Field split SHALL be x=data_in[3W-1:2W], y=data_in[2W-1:W], z=data_in[W-1:0] with W=COORD_W, passed through unmodified with no arithmetic.
REQ-013 data_in SHALL be sampled on every rising edge where data_in_valid=1; each pulse is one word, and back-to-back pulses are distinct words.
REQ-014 All outputs SHALL be registered; the output stage and the FIFO together form a FIFO_DEPTH+1-entry in-order queue.
REQ-015 Bypass: when the output register is empty (or being consumed the same edge) and the FIFO is empty, a sampled word SHALL load directly into the output register, so data_valid rises 1 cycle after the sampling edge.
REQ-016 When the output register is free and the FIFO is non-empty, the FIFO head SHALL load into the output register on that edge; the incoming word, if any, is written to the FIFO.
REQ-017 data_valid SHALL stay high and the coordinate outputs SHALL stay stable until the accepting edge; data_ready while data_valid=0 has no effect.
REQ-018 On accept with nothing pending, data_valid SHALL fall on that edge and the coordinate outputs SHALL retain the last value.
REQ-019 Simultaneous accept and incoming word with the FIFO empty: the new word SHALL replace the output the same edge and data_valid SHALL stay high.
REQ-020 Full (output valid, FIFO holds FIFO_DEPTH words, no accept this edge): an incoming word SHALL be silently dropped and stored data SHALL be unchanged.
REQ-021 If an accept occurs on the same edge as an incoming word while full, the incoming word SHALL be kept, because the accept frees space.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter from 0 to FIFO_DEPTH distinguishing full from empty.

Reset
REQ-023 reset_n=0 SHALL asynchronously clear data_valid to 0, x_coord, y_coord and z_coord to 0, and FIFO pointers and count to 0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all buffered and presented words; inputs sampled while reset_n=0 are ignored.
REQ-025 The first edge after reset_n deasserts SHALL behave as a normal edge.

Verification
REQ-026 The bench SHALL cover single word: after reset, pulse {10,20,30} -> next cycle data_valid=1, x=000a, y=0014, z=001e; held until data_ready; data_valid=0 after the accepting edge with values retained.
REQ-027 The bench SHALL cover sequence: words {15,25,35} then {1023,511,255}, each consumed -> outputs 000f/0019/0023, then 03ff/01ff/00ff, in order.
REQ-028 The bench SHALL cover burst: 5 back-to-back words with data_ready=0 -> all 5 retained; a 6th is dropped; holding data_ready=1 drains them in order, one per cycle.
REQ-029 The bench SHALL cover simultaneous events: accept while a new word arrives and the FIFO is empty -> data_valid stays 1 and outputs switch to the new word on that edge.
REQ-030 The bench SHALL cover reset mid-operation: with 3 words buffered, pulse reset_n low between edges -> data_valid=0 and outputs 0 immediately; a following word emerges alone.
